// File: rtl/dac_pkg.sv
// Shared definitions for the DAC setpoint controllers: widths, scan-FSM
// states, channel-index sizing and the per-channel slew arithmetic.
package dac_pkg;

  localparam int DAC_W   = 10;
  localparam int DAC_NCH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Bits needed to address nch channels (at least one bit).
  function automatic int ch_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Move cur toward tgt by at most step. The arithmetic is done in a signed
  // type wider than any DAC code, so the difference never wraps and the
  // result always lies between cur and tgt (no overshoot).
  function automatic int slew_step(input int cur, input int tgt, input int step);
    int d;
    d = tgt - cur;
    if (d > step)  return cur + step;
    if (d < -step) return cur - step;
    return tgt;
  endfunction

endpackage

// File: rtl/dac_slew_ctrl_tick_gen.sv
// Free-running divider: emits a one-cycle tick every DIV clocks, when the
// counter reaches DIV-1. Reusable by any slow periodic controller.
module tick_gen #(
  parameter int DIV = 4096
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Count 0..DIV-1 and wrap; reset restarts the period.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dac_slew_ctrl.sv
// Multi-channel DAC setpoint controller. The host writes per-channel targets;
// on every slew tick a scan FSM visits each channel once and moves its
// current code toward the target by at most STEP, so the analog control
// voltages ramp instead of stepping.
module dac_slew_ctrl
  import dac_pkg::*;
#(
  parameter int NCH       = DAC_NCH,
  parameter int W         = DAC_W,
  parameter int STEP      = 4,
  parameter int TICK_DIV  = 4096,
  parameter int RESET_VAL = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_ch,
  input  logic [W-1:0]     wr_data,
  input  logic             wr_imm,
  output logic [NCH*W-1:0] v_out,
  output logic [NCH-1:0]   busy,
  output logic             settled
);

  localparam int IW = ch_idx_w(NCH);

  // A scan takes NCH cycles plus one IDLE cycle to pick up the next tick;
  // a shorter tick period would drop ticks.
  if (TICK_DIV < NCH + 2) begin : g_bad_div
    $error("dac_slew_ctrl: TICK_DIV must be >= NCH+2");
  end
  if (NCH < 2 || NCH > 8) begin : g_bad_nch
    $error("dac_slew_ctrl: NCH must be in 2..8");
  end
  if (STEP < 1 || STEP > (1 << W) - 1) begin : g_bad_step
    $error("dac_slew_ctrl: STEP must be in 1..2^W-1");
  end

  logic tick;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_t         state, state_nx;
  logic [IW-1:0]  idx, idx_nx;
  logic [W-1:0]   tgt    [NCH];
  logic [W-1:0]   tgt_nx [NCH];
  logic [W-1:0]   cur    [NCH];
  logic [W-1:0]   cur_nx [NCH];
  logic [NCH-1:0] busy_nx;
  logic           settled_nx;

  logic           wr_fire;
  logic           wr_ch_ok;
  logic [IW-1:0]  wr_idx;

  // Writes are only taken between scans, so the scan never sees a target
  // change halfway through a channel visit.
  assign wr_ready = (state == ST_IDLE);
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_ch_ok = (int'(wr_ch) < NCH);
  assign wr_idx   = wr_ch[IW-1:0];

  // Scan FSM and datapath next-state: slew one channel per SCAN cycle, then
  // overlay any accepted host write.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_nx = state;
    idx_nx   = idx;
    tgt_nx   = tgt;
    cur_nx   = cur;

    unique case (state)
      ST_IDLE: begin
        if (tick) begin
          state_nx = ST_SCAN;
          idx_nx   = '0;
        end
      end
      ST_SCAN: begin
        cur_nx[idx] = W'(slew_step(int'(cur[idx]), int'(tgt[idx]), STEP));
        if (idx == IW'(NCH - 1)) state_nx = ST_IDLE;
        else                     idx_nx   = idx + 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase

    // A write only fires in IDLE, so it never collides with a slew update.
    if (wr_fire && wr_ch_ok) begin
      tgt_nx[wr_idx] = wr_data;
      if (wr_imm) cur_nx[wr_idx] = wr_data;
    end
  end

  // Status flags derived from next-state values so that, once registered,
  // they line up with v_out on the same cycle.
  always_comb begin
    busy_nx = '0;
    for (int k = 0; k < NCH; k++) busy_nx[k] = (cur_nx[k] != tgt_nx[k]);
    settled_nx = (busy_nx == '0) && (state_nx == ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Channel registers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the target/current arrays are reset explicitly because the
      // DAC outputs must come up at a defined code; plain storage arrays
      // would normally be left without reset.
      for (int k = 0; k < NCH; k++) begin
        tgt[k] <= W'(RESET_VAL);
        cur[k] <= W'(RESET_VAL);
      end
      busy    <= '0;
      settled <= 1'b1;
    end else begin
      tgt     <= tgt_nx;
      cur     <= cur_nx;
      busy    <= busy_nx;
      settled <= settled_nx;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_vout
    assign v_out[k*W +: W] = cur[k];
  end

endmodule

// File: tb/tb_dac_slew_ctrl.sv
// Directed self-checking bench for dac_slew_ctrl with NCH=4, STEP=4,
// TICK_DIV=16. Expected codes are tracked by hand in exp_v.
module tb_dac_slew_ctrl;

  localparam int NCH = 4;
  localparam int W   = 10;
  localparam int DIV = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [2:0]       wr_ch = '0;
  logic [W-1:0]     wr_data = '0;
  logic             wr_imm = 1'b0;
  logic [NCH*W-1:0] v_out;
  logic [NCH-1:0]   busy;
  logic             settled;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int tcnt    = 0;
  int exp_v [NCH];
  int waited;

  dac_slew_ctrl #(
    .NCH(NCH), .W(W), .STEP(4), .TICK_DIV(DIV), .RESET_VAL(512)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .wr_imm   (wr_imm),
    .v_out    (v_out),
    .busy     (busy),
    .settled  (settled)
  );

  always #5 clk = ~clk;

  // Bench-side model of the tick counter phase.
  always @(posedge clk) begin
    if (rst) tcnt <= 0;
    else     tcnt <= (tcnt == DIV - 1) ? 0 : tcnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [NCH*W-1:0] exp_vec();
    logic [NCH*W-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*W +: W] = W'(exp_v[k]);
    return r;
  endfunction

  function automatic int ch(input int k);
    return int'(v_out[k*W +: W]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a write and hold it until accepted; returns cycles spent waiting.
  task automatic do_write(input int c, input int data, input bit imm, output int n);
    wr_valid = 1'b1;
    wr_ch    = 3'(c);
    wr_data  = W'(data);
    wr_imm   = imm;
    n = 0;
    while (wr_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("wr_ready_before_accept", wr_ready, 1'b1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_scan_start();
    int n = 0;
    while (wr_ready !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    check("scan_start", wr_ready, 1'b0);
  endtask

  task automatic wait_scan_end(output int len);
    len = 0;
    while (wr_ready !== 1'b1 && len < 10) begin
      step();
      len++;
    end
    check("scan_end", wr_ready, 1'b1);
  endtask

  task automatic full_scan();
    int len;
    wait_scan_start();
    wait_scan_end(len);
  endtask

  // Stop in an IDLE cycle where the tick is high (next edge starts a scan).
  task automatic wait_tick_cycle();
    int n = 0;
    while ((tcnt != DIV - 1 || wr_ready !== 1'b1) && n < 40) begin
      step();
      n++;
    end
    check("tick_align", wr_ready, 1'b1);
  endtask

  initial begin
    int len;
    for (int k = 0; k < NCH; k++) exp_v[k] = 512;

    // Reset state
    rst = 1'b1;
    repeat (2) step();
    check("rst_vout", v_out, exp_vec());
    check("rst_busy", busy, 4'b0000);
    check("rst_settled", settled, 1'b1);
    check("rst_ready", wr_ready, 1'b1);
    rst = 1'b0;

    // Slew up: ch1 512 -> 516 -> 520
    do_write(1, 520, 1'b0, waited);
    check("up_vout_hold", v_out, exp_vec());
    check("up_busy", busy, 4'b0010);
    check("up_settled", settled, 1'b0);
    wait_scan_start();
    check("up_scan_c0", ch(1), 512);
    step();
    check("up_scan_c1", ch(1), 512);
    step();
    check("up_scan_c2", ch(1), 516);
    wait_scan_end(len);
    exp_v[1] = 516;
    check("up_tick1", v_out, exp_vec());
    check("up_tick1_busy", busy, 4'b0010);
    check("up_tick1_settled", settled, 1'b0);
    full_scan();
    exp_v[1] = 520;
    check("up_tick2", v_out, exp_vec());
    check("up_tick2_busy", busy, 4'b0000);
    check("up_tick2_settled", settled, 1'b1);

    // Slew down with remainder: ch0 512 -> 508 -> 505
    do_write(0, 505, 1'b0, waited);
    full_scan();
    exp_v[0] = 508;
    check("dn_tick1", v_out, exp_vec());
    full_scan();
    exp_v[0] = 505;
    check("dn_tick2", v_out, exp_vec());
    check("dn_busy", busy, 4'b0000);

    // Low extreme: ch3 2 -> 0
    do_write(3, 2, 1'b1, waited);
    exp_v[3] = 2;
    check("lo_imm", v_out, exp_vec());
    do_write(3, 0, 1'b0, waited);
    check("lo_busy", busy, 4'b1000);
    full_scan();
    exp_v[3] = 0;
    check("lo_tick", v_out, exp_vec());
    check("lo_busy_clr", busy, 4'b0000);

    // High extreme: ch3 1021 -> 1023, no wrap
    do_write(3, 1021, 1'b1, waited);
    do_write(3, 1023, 1'b0, waited);
    full_scan();
    exp_v[3] = 1023;
    check("hi_tick", v_out, exp_vec());
    check("hi_settled", settled, 1'b1);

    // Immediate write: ch2 -> 100 the cycle after accept, never busy
    do_write(2, 100, 1'b1, waited);
    exp_v[2] = 100;
    check("imm_vout", v_out, exp_vec());
    check("imm_busy", busy, 4'b0000);
    full_scan();
    check("imm_after_scan", v_out, exp_vec());

    // Write held across a tick: ready low for exactly NCH cycles
    wait_tick_cycle();
    step();
    do_write(0, 300, 1'b1, waited);
    check("hold_wait_cycles", waited, 4);
    exp_v[0] = 300;
    check("hold_vout", v_out, exp_vec());
    check("hold_ready", wr_ready, 1'b1);

    // Write coinciding with tick: scan uses the new target
    wait_tick_cycle();
    do_write(1, 530, 1'b0, waited);
    check("coll_in_scan", wr_ready, 1'b0);
    wait_scan_end(len);
    exp_v[1] = 524;
    check("coll_tick", v_out, exp_vec());
    full_scan();
    full_scan();
    exp_v[1] = 530;
    check("coll_final", v_out, exp_vec());
    check("coll_settled", settled, 1'b1);

    // Out-of-range channel: accepted and dropped
    do_write(5, 0, 1'b1, waited);
    check("oor_vout", v_out, exp_vec());
    check("oor_busy", busy, 4'b0000);
    full_scan();
    check("oor_after_scan", v_out, exp_vec());
    check("oor_settled", settled, 1'b1);

    // Reset asserted mid-scan
    do_write(0, 600, 1'b0, waited);
    wait_scan_start();
    rst = 1'b1;
    step();
    for (int k = 0; k < NCH; k++) exp_v[k] = 512;
    check("mrst_vout", v_out, exp_vec());
    check("mrst_busy", busy, 4'b0000);
    check("mrst_settled", settled, 1'b1);
    check("mrst_ready", wr_ready, 1'b1);
    rst = 1'b0;
    full_scan();
    check("mrst_after_scan", v_out, exp_vec());
    check("mrst_after_settled", settled, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
